// File: rtl/rtc_bus_pkg.sv
// Shared constants, state encoding and strobe decode for the RTC AD-bus
// read and write controllers.
package rtc_bus_pkg;

  localparam int unsigned BUS_W      = 8;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned T_ADDR_DEF = 20;
  localparam int unsigned T_GAP_DEF  = 4;
  localparam int unsigned T_READ_DEF = 20;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_GAP  = 3'd2,
    ST_READ = 3'd3,
    ST_DONE = 3'd4
  } rtc_state_e;

  typedef struct packed {
    logic cs_n;
    logic rd_n;
    logic wr_n;
    logic ad;
    logic bus_oe;
    logic busy;
    logic done;
  } strobe_t;

  localparam strobe_t STROBE_IDLE = '{
    cs_n:   1'b1,
    rd_n:   1'b1,
    wr_n:   1'b1,
    ad:     1'b0,
    bus_oe: 1'b0,
    busy:   1'b0,
    done:   1'b0
  };

  // Strobe levels the bus should show while in a given state.
  function automatic strobe_t strobes_for(input rtc_state_e st);
    strobe_t s;
    s = STROBE_IDLE;
    case (st)
      ST_ADDR: begin
        s.cs_n   = 1'b0;
        s.bus_oe = 1'b1;
        s.busy   = 1'b1;
      end
      ST_GAP: begin
        s.busy = 1'b1;
      end
      ST_READ: begin
        s.cs_n = 1'b0;
        s.rd_n = 1'b0;
        s.ad   = 1'b1;
        s.busy = 1'b1;
      end
      ST_DONE: begin
        s.busy = 1'b1;
        s.done = 1'b1;
      end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rtc_bus_read_ctrl_if.sv
// Request and AD-bus pad signals of the RTC read controller.
interface rtc_bus_read_ctrl_if;
  import rtc_bus_pkg::*;

  logic             start;
  logic [BUS_W-1:0] addr;
  logic [BUS_W-1:0] bus_in;
  logic [BUS_W-1:0] bus_out;
  logic             bus_oe;
  logic             cs_n;
  logic             rd_n;
  logic             wr_n;
  logic             ad;
  logic [BUS_W-1:0] data_out;
  logic             busy;
  logic             done;

  modport master (
    output start, addr, bus_in,
    input  bus_out, bus_oe, cs_n, rd_n, wr_n, ad, data_out, busy, done
  );

  modport slave (
    input  start, addr, bus_in,
    output bus_out, bus_oe, cs_n, rd_n, wr_n, ad, data_out, busy, done
  );

endinterface

// File: rtl/rtc_bus_read_ctrl_phase_timer.sv
// Loadable down-counter that times one bus phase; holds at zero until reloaded.
module phase_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/rtc_bus_read_ctrl.sv
// RTC register read cycle: address phase, bus turnaround, timed RD strobe,
// then capture of the returned byte.
module rtc_bus_read_ctrl
  import rtc_bus_pkg::*;
#(
  parameter int unsigned T_ADDR = T_ADDR_DEF,
  parameter int unsigned T_GAP  = T_GAP_DEF,
  parameter int unsigned T_READ = T_READ_DEF
) (
  input logic                clk,
  input logic                reset,
  rtc_bus_read_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] LD_ADDR = CNT_W'(T_ADDR - 1);
  localparam logic [CNT_W-1:0] LD_GAP  = CNT_W'(T_GAP - 1);
  localparam logic [CNT_W-1:0] LD_READ = CNT_W'(T_READ - 1);

  rtc_state_e       state_q,    state_d;
  logic [BUS_W-1:0] addr_q,     addr_d;
  logic [BUS_W-1:0] data_q,     data_d;
  logic [BUS_W-1:0] bus_out_q,  bus_out_d;
  strobe_t          strobe_q,   strobe_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_zero;

  phase_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .zero     (tmr_zero)
  );

  // Outputs are decoded from the next state so the registered pins line up
  // with the state they describe.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          addr_d       = bus.addr;
          tmr_load     = 1'b1;
          tmr_load_val = LD_ADDR;
          state_d      = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (tmr_zero) begin
          tmr_load     = 1'b1;
          tmr_load_val = LD_GAP;
          state_d      = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tmr_zero) begin
          tmr_load     = 1'b1;
          tmr_load_val = LD_READ;
          state_d      = ST_READ;
        end
      end
      ST_READ: begin
        if (tmr_zero) begin
          data_d  = bus.bus_in;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    strobe_d  = strobes_for(state_d);
    bus_out_d = (state_d == ST_ADDR) ? addr_d : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      bus_out_q <= '0;
      strobe_q  <= STROBE_IDLE;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      bus_out_q <= bus_out_d;
      strobe_q  <= strobe_d;
    end
  end

  assign bus.bus_out  = bus_out_q;
  assign bus.bus_oe   = strobe_q.bus_oe;
  assign bus.cs_n     = strobe_q.cs_n;
  assign bus.rd_n     = strobe_q.rd_n;
  assign bus.wr_n     = strobe_q.wr_n;
  assign bus.ad       = strobe_q.ad;
  assign bus.data_out = data_q;
  assign bus.busy     = strobe_q.busy;
  assign bus.done     = strobe_q.done;

endmodule

// File: tb/tb_rtc_bus_read_ctrl.sv
// Directed checks of the RTC read controller: default timing and a minimal
// 1/1/1 timing instance.
module tb_rtc_bus_read_ctrl;
  import rtc_bus_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rtc_bus_read_ctrl_if bus_if ();
  rtc_bus_read_ctrl_if b1_if ();

  rtc_bus_read_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  rtc_bus_read_ctrl #(.T_ADDR(1), .T_GAP(1), .T_READ(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1_if)
  );

  typedef struct {
    int         cyc;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       ad;
    logic       bus_oe;
    logic       busy;
    logic       done;
    logic [7:0] bus_out;
    logic [7:0] data_out;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int viol  = 0;

  function automatic vec_t mk(input int c, input logic cs, input logic rd, input logic a,
                              input logic oe, input logic bsy, input logic dn,
                              input logic [7:0] bo, input logic [7:0] dout);
    vec_t v;
    v.cyc = c; v.cs_n = cs; v.rd_n = rd; v.wr_n = 1'b1; v.ad = a;
    v.bus_oe = oe; v.busy = bsy; v.done = dn; v.bus_out = bo; v.data_out = dout;
    return v;
  endfunction

  function automatic vec_t samp0(input int c);
    vec_t v;
    v.cyc = c; v.cs_n = bus_if.cs_n; v.rd_n = bus_if.rd_n; v.wr_n = bus_if.wr_n;
    v.ad = bus_if.ad; v.bus_oe = bus_if.bus_oe; v.busy = bus_if.busy;
    v.done = bus_if.done; v.bus_out = bus_if.bus_out; v.data_out = bus_if.data_out;
    return v;
  endfunction

  function automatic vec_t samp1(input int c);
    vec_t v;
    v.cyc = c; v.cs_n = b1_if.cs_n; v.rd_n = b1_if.rd_n; v.wr_n = b1_if.wr_n;
    v.ad = b1_if.ad; v.bus_oe = b1_if.bus_oe; v.busy = b1_if.busy;
    v.done = b1_if.done; v.bus_out = b1_if.bus_out; v.data_out = b1_if.data_out;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic cmp(input string tag, input vec_t e, input vec_t g);
    string p;
    p = $sformatf("%s@c%0d", tag, e.cyc);
    chk({p, ".cs_n"},     8'(g.cs_n),   8'(e.cs_n));
    chk({p, ".rd_n"},     8'(g.rd_n),   8'(e.rd_n));
    chk({p, ".wr_n"},     8'(g.wr_n),   8'(e.wr_n));
    chk({p, ".ad"},       8'(g.ad),     8'(e.ad));
    chk({p, ".bus_oe"},   8'(g.bus_oe), 8'(e.bus_oe));
    chk({p, ".busy"},     8'(g.busy),   8'(e.busy));
    chk({p, ".done"},     8'(g.done),   8'(e.done));
    chk({p, ".bus_out"},  g.bus_out,    e.bus_out);
    chk({p, ".data_out"}, g.data_out,   e.data_out);
  endtask

  // Bus-contention and idle-drive invariants, watched on every cycle.
  always @(negedge clk) begin
    if (bus_if.bus_oe && !bus_if.rd_n) viol++;
    if (!bus_if.bus_oe && (bus_if.bus_out != 8'h00)) viol++;
    if (bus_if.wr_n == 1'b0) viol++;
    if (b1_if.bus_oe && !b1_if.rd_n) viol++;
    if (!b1_if.bus_oe && (b1_if.bus_out != 8'h00)) viol++;
    if (b1_if.wr_n == 1'b0) viol++;
  end

  vec_t vreset;
  vec_t vt[8];
  vec_t vt1[5];

  initial begin
    int dcount;
    int dfirst;
    int dsecond;

    vreset = mk(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    vt[0] = mk( 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h2A, 8'h00);
    vt[1] = mk(20, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h2A, 8'h00);
    vt[2] = mk(21, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    vt[3] = mk(24, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    vt[4] = mk(25, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    vt[5] = mk(44, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    vt[6] = mk(45, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h59);
    vt[7] = mk(46, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h59);

    vt1[0] = mk(1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h9C, 8'h00);
    vt1[1] = mk(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    vt1[2] = mk(3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    vt1[3] = mk(4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'hA5);
    vt1[4] = mk(5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hA5);

    reset = 1'b1;
    bus_if.start = 1'b0; bus_if.addr = 8'h00; bus_if.bus_in = 8'h00;
    b1_if.start  = 1'b0; b1_if.addr  = 8'h00; b1_if.bus_in  = 8'h00;
    repeat (2) @(negedge clk);
    cmp("reset0", vreset, samp0(0));
    cmp("reset1", vreset, samp1(0));
    reset = 1'b0;

    // Basic read with default timing, checked against the vector table.
    bus_if.addr = 8'h2A; bus_if.bus_in = 8'h59; bus_if.start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 46; c++) begin
      @(negedge clk);
      if (c == 1) bus_if.start = 1'b0;
      for (int i = 0; i < 8; i++)
        if (vt[i].cyc == c) cmp("basic", vt[i], samp0(c));
    end

    // Late bus_in change in the final READ cycle is the value captured.
    bus_if.addr = 8'h33; bus_if.bus_in = 8'h11; bus_if.start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 48; c++) begin
      @(negedge clk);
      if (c == 1) bus_if.start = 1'b0;
      if (c == 43) chk("late.data_before", bus_if.data_out, 8'h59);
      if (c == 44) bus_if.bus_in = 8'h77;
      if (c == 45) begin
        chk("late.done", 8'(bus_if.done), 8'h01);
        chk("late.data_cap", bus_if.data_out, 8'h77);
        bus_if.bus_in = 8'hEE;
      end
      if (c == 47) chk("late.data_hold", bus_if.data_out, 8'h77);
    end

    // Starts while busy are ignored.
    bus_if.addr = 8'h2A; bus_if.bus_in = 8'h3C; bus_if.start = 1'b1;
    @(posedge clk);
    dcount = 0; dfirst = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus_if.done) begin
        dcount++;
        if (dfirst < 0) dfirst = c;
      end
      if (c == 1 || c == 11 || c == 31) bus_if.start = 1'b0;
      if (c == 10 || c == 30) begin bus_if.start = 1'b1; bus_if.addr = 8'hC3; end
      if (c == 15) chk("ign.bus_out15", bus_if.bus_out, 8'h2A);
      if (c == 20) chk("ign.bus_out20", bus_if.bus_out, 8'h2A);
      if (c == 32) chk("ign.rd_n32", 8'(bus_if.rd_n), 8'h00);
    end
    chk("ign.done_count", 8'(dcount), 8'd1);
    chk("ign.done_cycle", 8'(dfirst), 8'd45);
    chk("ign.data", bus_if.data_out, 8'h3C);

    // start held high: back-to-back reads.
    bus_if.addr = 8'h05; bus_if.bus_in = 8'h42; bus_if.start = 1'b1;
    @(posedge clk);
    dcount = 0; dfirst = -1; dsecond = -1;
    for (int c = 1; c <= 92; c++) begin
      @(negedge clk);
      if (bus_if.done) begin
        dcount++;
        if (dfirst < 0) dfirst = c;
        else if (dsecond < 0) dsecond = c;
      end
      if (c == 46) begin
        chk("b2b.idle_cs_n", 8'(bus_if.cs_n), 8'h01);
        chk("b2b.idle_busy", 8'(bus_if.busy), 8'h00);
      end
      if (c == 47) begin
        chk("b2b.addr2_bus", bus_if.bus_out, 8'h05);
        chk("b2b.addr2_cs_n", 8'(bus_if.cs_n), 8'h00);
      end
      if (c == 92) bus_if.start = 1'b0;
    end
    chk("b2b.done_count", 8'(dcount), 8'd2);
    chk("b2b.first", 8'(dfirst), 8'd45);
    chk("b2b.spacing", 8'(dsecond - dfirst), 8'd46);
    repeat (50) @(negedge clk);
    chk("b2b.final_busy", 8'(bus_if.busy), 8'h00);

    // Reset during READ aborts the cycle and clears data_out.
    bus_if.addr = 8'h2A; bus_if.bus_in = 8'h59; bus_if.start = 1'b1;
    @(posedge clk);
    dcount = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) bus_if.start = 1'b0;
      if (c == 29) chk("rst.data_before", bus_if.data_out, 8'h42);
      if (c >= 31 && bus_if.done) dcount++;
      if (c == 30) reset = 1'b1;
      if (c == 31) begin
        cmp("rst", vreset, samp0(31));
        reset = 1'b0;
      end
    end
    chk("rst.no_done", 8'(dcount), 8'd0);

    // Minimal timing instance.
    b1_if.addr = 8'h9C; b1_if.bus_in = 8'hA5; b1_if.start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) b1_if.start = 1'b0;
      for (int i = 0; i < 5; i++)
        if (vt1[i].cyc == c) cmp("min", vt1[i], samp1(c));
    end

    chk("invariants", 8'(viol), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
